// File: rtl/keycode_dir_scheduler.sv
// keycode_dir_scheduler
// Turns the raw HID keycode from the keycode PIO into Pacman game control.
// It detects key presses, buffers a requested direction until the maze
// logic reports that turn as legal on a frame tick, and runs the
// IDLE/RUN/PAUSE game FSM. Everything runs in the clk domain.
//
// Handshake note: there is no valid/ready pair on this block. A press event
// is the one-cycle condition (keycode != key_q && keycode != 0). frame_tick
// is a one-cycle strobe. start_pulse and dir_changed are one-cycle strobes,
// registered, and aligned with the state/cur_dir/moving update they describe.
module keycode_dir_scheduler #(
  parameter int PEND_FRAMES = 8,
  parameter int AGE_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic [3:0] turn_ok,
  input  logic       game_over,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       pend_valid,
  output logic [1:0] pend_dir,
  output logic [1:0] state,
  output logic       start_pulse,
  output logic       dir_changed
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // age value at which the next blocked tick drops the request
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(PEND_FRAMES - 1);

  logic [7:0]       key_q;
  logic [AGE_W-1:0] age;

  logic             press;
  logic             is_dir;
  logic [1:0]       dir_code;
  logic             is_start;
  logic             is_pause;
  logic             dir_ev;
  logic             start_ev;
  logic             pause_ev;

  logic [1:0]       next_state;
  logic             start_d;

  logic             tick_run;
  logic             reversal;
  logic             legal;
  logic             commit;
  logic [1:0]       nx_cur_dir;
  logic             nx_moving;
  logic             nx_pend_valid;
  logic [1:0]       nx_pend_dir;
  logic [AGE_W-1:0] nx_age;
  logic             nx_dir_changed;

  // A press is a change to a non-zero code; holding or releasing is not.
  assign press    = (keycode != key_q) && (keycode != 8'h00);
  assign dir_ev   = press && is_dir;
  assign start_ev = press && is_start;
  assign pause_ev = press && is_pause;

  // Previous-cycle keycode, used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_q <= 8'h00;
    else          key_q <= keycode;
  end

  // Decode the live keycode into a direction or a control command.
  always_comb begin
    is_dir   = 1'b0;
    dir_code = 2'd0;
    is_start = 1'b0;
    is_pause = 1'b0;
    case (keycode)
      8'h1A, 8'h52: begin is_dir = 1'b1; dir_code = 2'd0; end
      8'h07, 8'h4F: begin is_dir = 1'b1; dir_code = 2'd1; end
      8'h16, 8'h51: begin is_dir = 1'b1; dir_code = 2'd2; end
      8'h04, 8'h50: begin is_dir = 1'b1; dir_code = 2'd3; end
      8'h28:        is_start = 1'b1;
      8'h13:        is_pause = 1'b1;
      default:      ;
    endcase
  end

  // Game FSM state register; start_pulse is registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      start_pulse <= 1'b0;
    end else begin
      state       <= next_state;
      start_pulse <= start_d;
    end
  end

  // Game FSM next state; game_over overrides any key event.
  always_comb begin
    next_state = state;
    if (game_over) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ev) next_state = ST_RUN;
        ST_RUN:   if (pause_ev) next_state = ST_PAUSE;
        ST_PAUSE: if (pause_ev) next_state = ST_RUN;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Game FSM output: flag the IDLE->RUN transition only (not PAUSE->RUN).
  always_comb begin
    start_d = (state == ST_IDLE) && (next_state == ST_RUN);
  end

  // Movement datapath: tick resolution first, then a new request overwrites.
  always_comb begin
    nx_cur_dir     = cur_dir;
    nx_moving      = moving;
    nx_pend_valid  = pend_valid;
    nx_pend_dir    = pend_dir;
    nx_age         = age;
    nx_dir_changed = 1'b0;

    tick_run = frame_tick && (state == ST_RUN);
    reversal = pend_valid && moving && (pend_dir == (cur_dir ^ 2'd2));
    legal    = pend_valid && turn_ok[pend_dir];
    commit   = tick_run && (reversal || legal);

    if (game_over) begin
      nx_moving     = 1'b0;
      nx_pend_valid = 1'b0;
      nx_age        = '0;
    end else begin
      if (commit) begin
        nx_cur_dir    = pend_dir;
        nx_moving     = 1'b1;
        nx_pend_valid = 1'b0;
      end else if (tick_run) begin
        if (pend_valid) begin
          if (age == AGE_LAST) nx_pend_valid = 1'b0;
          else                 nx_age = age + AGE_W'(1);
        end
        if (moving && !turn_ok[cur_dir]) nx_moving = 1'b0;
      end

      if (tick_run)
        nx_dir_changed = (nx_cur_dir != cur_dir) || (nx_moving != moving);

      if (dir_ev && ((state == ST_RUN) || (state == ST_PAUSE))) begin
        nx_pend_valid = 1'b1;
        nx_pend_dir   = dir_code;
        nx_age        = '0;
      end
    end
  end

  // Movement datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_dir     <= 2'd0;
      moving      <= 1'b0;
      pend_valid  <= 1'b0;
      pend_dir    <= 2'd0;
      age         <= '0;
      dir_changed <= 1'b0;
    end else begin
      cur_dir     <= nx_cur_dir;
      moving      <= nx_moving;
      pend_valid  <= nx_pend_valid;
      pend_dir    <= nx_pend_dir;
      age         <= nx_age;
      dir_changed <= nx_dir_changed;
    end
  end

endmodule

// File: tb/tb_keycode_dir_scheduler.sv
// Bench for keycode_dir_scheduler: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the game rules.
module tb_keycode_dir_scheduler;

  localparam int PEND_FRAMES = 8;

  // clock/reset block
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic [3:0] turn_ok = 4'h0;
  logic       game_over = 1'b0;
  logic [1:0] cur_dir;
  logic       moving;
  logic       pend_valid;
  logic [1:0] pend_dir;
  logic [1:0] state;
  logic       start_pulse;
  logic       dir_changed;

  always #5 clk = ~clk;

  keycode_dir_scheduler #(.PEND_FRAMES(PEND_FRAMES), .AGE_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .keycode(keycode), .frame_tick(frame_tick),
    .turn_ok(turn_ok), .game_over(game_over), .cur_dir(cur_dir), .moving(moving),
    .pend_valid(pend_valid), .pend_dir(pend_dir), .state(state),
    .start_pulse(start_pulse), .dir_changed(dir_changed)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // game: 0 idle, 1 running, 2 paused
  int         m_game;
  logic [7:0] m_last_key;
  logic [1:0] m_dir;
  logic       m_move;
  logic       m_req;
  logic [1:0] m_req_dir;
  int         m_blocked_ticks;
  logic       m_start;
  logic       m_changed;

  // key meaning: 0..3 direction, 4 start, 5 pause, -1 nothing
  function automatic int key_meaning(input logic [7:0] k);
    int r;
    r = -1;
    if (k == 8'h1A || k == 8'h52) r = 0;
    if (k == 8'h07 || k == 8'h4F) r = 1;
    if (k == 8'h16 || k == 8'h51) r = 2;
    if (k == 8'h04 || k == 8'h50) r = 3;
    if (k == 8'h28) r = 4;
    if (k == 8'h13) r = 5;
    return r;
  endfunction

  task automatic model_reset();
    m_game = 0; m_last_key = 8'h00; m_dir = 2'd0; m_move = 1'b0;
    m_req = 1'b0; m_req_dir = 2'd0; m_blocked_ticks = 0;
    m_start = 1'b0; m_changed = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input logic [7:0] k, input logic tk,
                            input logic [3:0] tok, input logic go);
    int         meaning;
    logic       pressed;
    int         old_game;
    logic [1:0] old_dir;
    logic       old_move;
    logic       took;
    meaning  = key_meaning(k);
    pressed  = (k != m_last_key) && (k != 8'h00);
    old_game = m_game;
    old_dir  = m_dir;
    old_move = m_move;
    m_start   = 1'b0;
    m_changed = 1'b0;
    if (go) begin
      m_game = 0;
      m_move = 1'b0;
      m_req  = 1'b0;
    end else begin
      if (pressed && old_game == 0 && meaning == 4) begin
        m_game = 1; m_start = 1'b1;
      end else if (pressed && old_game != 0 && meaning == 5) begin
        m_game = (old_game == 1) ? 2 : 1;
      end
      if (old_game == 1 && tk) begin
        took = 1'b0;
        if (m_req) begin
          if ((old_move && m_req_dir == old_dir + 2'd2) || tok[m_req_dir]) begin
            m_dir = m_req_dir; m_move = 1'b1; m_req = 1'b0; took = 1'b1;
          end else begin
            m_blocked_ticks++;
            if (m_blocked_ticks >= PEND_FRAMES) m_req = 1'b0;
          end
        end
        if (!took && old_move && !tok[old_dir]) m_move = 1'b0;
        m_changed = (m_dir != old_dir) || (m_move != old_move);
      end
      if (pressed && old_game != 0 && meaning >= 0 && meaning <= 3) begin
        m_req = 1'b1; m_req_dir = meaning[1:0]; m_blocked_ticks = 0;
      end
    end
    m_last_key = k;
  endtask

  // driver: apply one cycle of inputs, advance model, sample after the edge
  task automatic drive_cycle(input logic [7:0] k, input logic tk,
                             input logic [3:0] tok, input logic go);
    keycode = k; frame_tick = tk; turn_ok = tok; game_over = go;
    model_step(k, tk, tok, go);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    keycode = 8'($urandom_range(1, 255));
    frame_tick = 1'b1; turn_ok = 4'hF; game_over = 1'b0;
    #2;
    checks++;
    if ({cur_dir, moving, pend_valid, pend_dir, state, start_pulse, dir_changed} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got cur_dir=%0d moving=%0b pv=%0b pd=%0d state=%0d sp=%0b dc=%0b want all 0",
               cur_dir, moving, pend_valid, pend_dir, state, start_pulse, dir_changed);
    end
    @(posedge clk); #1;
    keycode = 8'h00; frame_tick = 1'b0; turn_ok = 4'h0;
    reset_n = 1'b1;
    model_reset();
    drive_cycle(8'h00, 1'b0, 4'h0, 1'b0);
    checks++;
    if (state !== 2'd0 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got state=%0d pv=%0b want 0 0", state, pend_valid);
    end
  endtask

  task automatic test_start();
    drive_cycle(8'h28, 1'b0, 4'h0, 1'b0);
    checks++;
    if (state !== 2'd1 || start_pulse !== 1'b1) begin
      errors++;
      $display("FAIL start_enter got state=%0d sp=%0b want 1 1", state, start_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(8'h28, 1'b0, 4'h0, 1'b0);
      checks++;
      if (start_pulse !== 1'b0 || state !== 2'd1) begin
        errors++;
        $display("FAIL start_hold cyc %0d got sp=%0b state=%0d want 0 1", i, start_pulse, state);
      end
    end
    drive_cycle(8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_legal_turn();
    drive_cycle(8'h4F, 1'b0, 4'b0010, 1'b0);
    checks++;
    if (pend_valid !== 1'b1 || pend_dir !== 2'd1) begin
      errors++;
      $display("FAIL turn_buffer got pv=%0b pd=%0d want 1 1", pend_valid, pend_dir);
    end
    drive_cycle(8'h00, 1'b1, 4'b0010, 1'b0);
    checks++;
    if (cur_dir !== 2'd1 || moving !== 1'b1 || pend_valid !== 1'b0 || dir_changed !== 1'b1) begin
      errors++;
      $display("FAIL turn_commit got cd=%0d mv=%0b pv=%0b dc=%0b want 1 1 0 1",
               cur_dir, moving, pend_valid, dir_changed);
    end
    drive_cycle(8'h00, 1'b0, 4'b0010, 1'b0);
    checks++;
    if (dir_changed !== 1'b0) begin
      errors++;
      $display("FAIL turn_dc_pulse got dc=%0b want 0", dir_changed);
    end
  endtask

  task automatic test_blocked_expiry();
    drive_cycle(8'h1A, 1'b0, 4'b0010, 1'b0);
    for (int t = 1; t <= PEND_FRAMES; t++) begin
      drive_cycle(8'h00, 1'b1, 4'b0010, 1'b0);
      checks++;
      if (pend_valid !== (t < PEND_FRAMES) || pend_dir !== 2'd0 ||
          moving !== 1'b1 || cur_dir !== 2'd1) begin
        errors++;
        $display("FAIL blocked_tick %0d got pv=%0b pd=%0d mv=%0b cd=%0d want %0b 0 1 1",
                 t, pend_valid, pend_dir, moving, cur_dir, (t < PEND_FRAMES));
      end
    end
  endtask

  task automatic test_reversal();
    drive_cycle(8'h50, 1'b0, 4'b0000, 1'b0);
    drive_cycle(8'h00, 1'b1, 4'b0000, 1'b0);
    checks++;
    if (cur_dir !== 2'd3 || moving !== 1'b1 || pend_valid !== 1'b0 || dir_changed !== 1'b1) begin
      errors++;
      $display("FAIL reversal got cd=%0d mv=%0b pv=%0b dc=%0b want 3 1 0 1",
               cur_dir, moving, pend_valid, dir_changed);
    end
    drive_cycle(8'h00, 1'b1, 4'b0000, 1'b0);
    checks++;
    if (cur_dir !== 2'd3 || moving !== 1'b0 || dir_changed !== 1'b1) begin
      errors++;
      $display("FAIL wall_stop got cd=%0d mv=%0b dc=%0b want 3 0 1", cur_dir, moving, dir_changed);
    end
  endtask

  task automatic test_pause();
    drive_cycle(8'h13, 1'b0, 4'hF, 1'b0);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_enter got state=%0d want 2", state);
    end
    drive_cycle(8'h52, 1'b0, 4'hF, 1'b0);
    checks++;
    if (pend_valid !== 1'b1 || pend_dir !== 2'd0) begin
      errors++;
      $display("FAIL pause_buffer got pv=%0b pd=%0d want 1 0", pend_valid, pend_dir);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'h00, 1'b1, 4'hF, 1'b0);
      checks++;
      if (cur_dir !== 2'd3 || moving !== 1'b0 || pend_valid !== 1'b1 || dir_changed !== 1'b0) begin
        errors++;
        $display("FAIL pause_tick %0d got cd=%0d mv=%0b pv=%0b dc=%0b want 3 0 1 0",
                 i, cur_dir, moving, pend_valid, dir_changed);
      end
    end
    drive_cycle(8'h13, 1'b0, 4'hF, 1'b0);
    checks++;
    if (state !== 2'd1 || start_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume got state=%0d sp=%0b want 1 0", state, start_pulse);
    end
  endtask

  task automatic test_tick_with_event();
    drive_cycle(8'h51, 1'b1, 4'b0001, 1'b0);
    checks++;
    if (cur_dir !== 2'd0 || moving !== 1'b1 || pend_valid !== 1'b1 || pend_dir !== 2'd2) begin
      errors++;
      $display("FAIL tick_event got cd=%0d mv=%0b pv=%0b pd=%0d want 0 1 1 2",
               cur_dir, moving, pend_valid, pend_dir);
    end
    drive_cycle(8'h00, 1'b0, 4'b0001, 1'b1);
    checks++;
    if (state !== 2'd0 || moving !== 1'b0 || pend_valid !== 1'b0 || cur_dir !== 2'd0) begin
      errors++;
      $display("FAIL game_over got state=%0d mv=%0b pv=%0b cd=%0d want 0 0 0 0",
               state, moving, pend_valid, cur_dir);
    end
    drive_cycle(8'h28, 1'b0, 4'b0001, 1'b1);
    checks++;
    if (state !== 2'd0 || start_pulse !== 1'b0) begin
      errors++;
      $display("FAIL game_over_priority got state=%0d sp=%0b want 0 0", state, start_pulse);
    end
    drive_cycle(8'h00, 1'b0, 4'b0001, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] codes [10];
    logic [7:0] k;
    logic       tk;
    logic       go;
    codes = '{8'h28, 8'h13, 8'h1A, 8'h52, 8'h07, 8'h4F, 8'h16, 8'h51, 8'h04, 8'h50};
    k = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        // asynchronous reset in the middle of a cycle
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cur_dir, moving, pend_valid, state} !== 6'd0) begin
          errors++;
          $display("FAIL rand_async_reset got cd=%0d mv=%0b pv=%0b state=%0d want 0",
                   cur_dir, moving, pend_valid, state);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        k = 8'h00;
      end
      case ($urandom_range(0, 9))
        0, 1, 2:       k = 8'h00;
        3, 4, 5, 6, 7: k = codes[$urandom_range(0, 9)];
        8:             k = 8'($urandom_range(0, 255));
        default:       ;
      endcase
      tk = ($urandom_range(0, 2) == 0);
      go = ($urandom_range(0, 80) == 0);
      drive_cycle(k, tk, 4'($urandom_range(0, 15)), go);
      checks++;
      if (cur_dir !== m_dir || moving !== m_move || pend_valid !== m_req ||
          (m_req && pend_dir !== m_req_dir) || state !== 2'(m_game) ||
          start_pulse !== m_start || dir_changed !== m_changed) begin
        errors++;
        $display("FAIL rand cyc %0d got cd=%0d mv=%0b pv=%0b pd=%0d st=%0d sp=%0b dc=%0b want %0d %0b %0b %0d %0d %0b %0b",
                 n, cur_dir, moving, pend_valid, pend_dir, state, start_pulse, dir_changed,
                 m_dir, m_move, m_req, m_req_dir, m_game, m_start, m_changed);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    model_reset();
    test_reset();
    test_start();
    test_legal_turn();
    test_blocked_expiry();
    test_reversal();
    test_pause();
    test_tick_with_event();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
